// File: rtl/chess_cursor.sv
// chess_cursor: ROWSxCOLS board cursor driven by W/A/S/D/ESC keys with a two-press ENTER move select.
// Define CHESS_CURSOR_WRAP_EN to wrap edge moves; by default they clamp.
module chess_cursor #(
    parameter int COLS = 8,
    parameter int ROWS = 8,
    parameter int RESET_COL = (COLS - 1) / 2,
    parameter int RESET_ROW = (ROWS - 1) / 2,
    localparam int CW = $clog2(COLS),
    localparam int RW = $clog2(ROWS),
    localparam int IW = $clog2(ROWS * COLS)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [7:0]    ascii,
    input  logic          new_ascii,
    input  logic          ENTER,
    output logic [CW-1:0] cur_col,
    output logic [RW-1:0] cur_row,
    output logic [IW-1:0] state,
    output logic          picked,
    output logic [IW-1:0] from_idx,
    output logic [IW-1:0] to_idx,
    output logic          move_valid
);
`ifdef CHESS_CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam logic [CW-1:0] CMAX = CW'(COLS - 1);
    localparam logic [RW-1:0] RMAX = RW'(ROWS - 1);

    typedef enum logic {IDLE, PICKED} fsm_t;
    fsm_t fsm, fsm_n;
    logic [7:0] lc;
    logic up, dn, lf, rt, esc;
    logic [CW-1:0] col_n;
    logic [RW-1:0] row_n;
    logic s1, s2, s3, rise, latch, fire;

    // folding bit 5 maps upper-case letters onto lower-case
    assign lc  = ascii | 8'h20;
    assign up  = new_ascii && lc == 8'h77;
    assign dn  = new_ascii && lc == 8'h73;
    assign lf  = new_ascii && lc == 8'h61;
    assign rt  = new_ascii && lc == 8'h64;
    assign esc = new_ascii && ascii == 8'h1B;

    assign col_n = lf ? (cur_col == '0 ? (WRAP ? CMAX : cur_col) : cur_col - 1'b1)
                 : rt ? (cur_col == CMAX ? (WRAP ? '0 : cur_col) : cur_col + 1'b1)
                 : cur_col;
    assign row_n = up ? (cur_row == '0 ? (WRAP ? RMAX : cur_row) : cur_row - 1'b1)
                 : dn ? (cur_row == RMAX ? (WRAP ? '0 : cur_row) : cur_row + 1'b1)
                 : cur_row;

    assign picked = fsm == PICKED;

    always_comb begin
        fsm_n = fsm;
        latch = 1'b0;
        fire  = 1'b0;
        if (fsm == IDLE) begin
            latch = rise;
            fsm_n = rise ? PICKED : IDLE;
        end else begin
            fire  = rise && state != from_idx;
            fsm_n = (rise || esc) ? IDLE : PICKED;
        end
    end

    // edge detect is registered so the FSM reacts one cycle after s2 rises
    always_ff @(posedge CLK) begin
        if (RESET) begin
            {s1, s2, s3, rise} <= '0;
        end else begin
            s1   <= ENTER;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fsm        <= IDLE;
            cur_col    <= CW'(RESET_COL);
            cur_row    <= RW'(RESET_ROW);
            state      <= IW'(RESET_ROW * COLS + RESET_COL);
            from_idx   <= '0;
            to_idx     <= '0;
            move_valid <= 1'b0;
        end else begin
            fsm        <= fsm_n;
            cur_col    <= col_n;
            cur_row    <= row_n;
            state      <= IW'(row_n) * IW'(COLS) + IW'(col_n);
            move_valid <= fire;
            if (latch) from_idx <= state;
            if (fire) to_idx <= state;
        end
    end
endmodule

// File: tb/tb_chess_cursor.sv
// tb_chess_cursor: directed checks of cursor moves, edge handling and ENTER move selection on 8x8.
module tb_chess_cursor;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] ascii = 8'h00;
    logic       new_ascii = 1'b0;
    logic       ENTER = 1'b0;
    logic [2:0] cur_col, cur_row;
    logic [5:0] state, from_idx, to_idx;
    logic       picked, move_valid;
    int total = 0;
    int bad = 0;
    int mv_cnt = 0;

    chess_cursor dut (
        .CLK(CLK), .RESET(RESET), .ascii(ascii), .new_ascii(new_ascii), .ENTER(ENTER),
        .cur_col(cur_col), .cur_row(cur_row), .state(state), .picked(picked),
        .from_idx(from_idx), .to_idx(to_idx), .move_valid(move_valid)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (move_valid === 1'b1) mv_cnt++;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic key(input logic [7:0] c);
        @(negedge CLK);
        ascii = c;
        new_ascii = 1'b1;
        @(negedge CLK);
        new_ascii = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic press();
        ENTER = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    task automatic release_enter();
        ENTER = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        chk("rst_col", cur_col, 3);
        chk("rst_row", cur_row, 3);
        chk("rst_state", state, 27);
        chk("rst_picked", picked, 0);
        chk("rst_mv", move_valid, 0);
        chk("rst_from", from_idx, 0);
        chk("rst_to", to_idx, 0);

        key("D"); chk("d1_state", state, 28);
        key("D"); chk("d2_col", cur_col, 5);
        key("S");
        chk("dds_row", cur_row, 4);
        chk("dds_state", state, 37);

        do_reset();
        repeat (4) key("A");
        chk("a4_col", cur_col, 0);
        chk("a4_state", state, 24);
        key("A");
`ifdef CHESS_CURSOR_WRAP_EN
        chk("a5_col", cur_col, 7);
        chk("a5_state", state, 31);
`else
        chk("a5_col", cur_col, 0);
        chk("a5_state", state, 24);
`endif
        key("x");
`ifdef CHESS_CURSOR_WRAP_EN
        chk("ignore_state", state, 31);
`else
        chk("ignore_state", state, 24);
`endif

        do_reset();
        ENTER = 1'b1;
        repeat (3) @(negedge CLK);
        chk("lat_picked_early", picked, 0);
        @(negedge CLK);
        chk("lat_picked", picked, 1);
        chk("lat_from", from_idx, 27);
        release_enter();
        key("w");
        chk("w_state", state, 19);
        press();
        chk("mv_pulse", move_valid, 1);
        chk("mv_from", from_idx, 27);
        chk("mv_to", to_idx, 19);
        chk("mv_picked", picked, 0);
        @(negedge CLK);
        chk("mv_one_cycle", move_valid, 0);
        release_enter();
        chk("mv_cnt1", mv_cnt, 1);

        do_reset();
        press(); release_enter();
        chk("twice_picked1", picked, 1);
        press();
        chk("twice_picked0", picked, 0);
        chk("twice_mv", move_valid, 0);
        release_enter();
        chk("twice_cnt", mv_cnt, 1);

        press();
        chk("esc_picked1", picked, 1);
        key(8'h1B);
        chk("esc_picked0", picked, 0);
        release_enter();
        chk("esc_cnt", mv_cnt, 1);
        key(8'h1B);
        chk("esc_idle_state", state, 27);
        chk("esc_idle_picked", picked, 0);

        press(); release_enter();
        chk("sim_from", from_idx, 27);
        key("d");
        chk("sim_pre_state", state, 28);
        ENTER = 1'b1;
        repeat (3) @(negedge CLK);
        ascii = "D";
        new_ascii = 1'b1;
        @(negedge CLK);
        new_ascii = 1'b0;
        chk("sim_mv", move_valid, 1);
        chk("sim_to", to_idx, 28);
        chk("sim_state", state, 29);
        chk("sim_picked", picked, 0);
        repeat (16) @(negedge CLK);
        chk("hold_picked", picked, 0);
        chk("hold_cnt", mv_cnt, 2);
        release_enter();

        press(); release_enter();
        chk("rp_picked", picked, 1);
        chk("rp_from", from_idx, 29);
        do_reset();
        chk("rp_after_picked", picked, 0);
        chk("rp_after_state", state, 27);
        chk("rp_after_mv", move_valid, 0);
        repeat (6) @(negedge CLK);
        chk("rp_cnt", mv_cnt, 2);
        chk("rp_idle", picked, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/chess_cursor.md
# chess_cursor

Parametrised board-cursor and move-selection controller for a ROWS×COLS board; it generalises the fixed 3×3 cursor field of the display path. Fully synchronous on one clock: it consumes single-cycle keyboard strobes (W/A/S/D moves, ESC cancels) and a raw ENTER button. It tracks the cursor position and runs a two-press select sequence that emits a from/to move pulse to the game logic.

## Interface
- COLS, default 8: board columns, ≥2.
- ROWS, default 8: board rows, ≥2.
- RESET_COL, default (COLS-1)/2: cursor column after reset.
- RESET_ROW, default (ROWS-1)/2: cursor row after reset.
- CLK  input  1  system clock; all state changes on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- ascii  input  8  active ASCII code; sampled only when new_ascii=1.
- new_ascii  input  1  one-cycle strobe: ascii holds a new key.
- ENTER  input  1  raw, asynchronous Enter button, active-high.
- cur_col  output  CW=$clog2(COLS)  cursor column, 0 = leftmost.
- cur_row  output  RW=$clog2(ROWS)  cursor row, 0 = top.
- state  output  IW=$clog2(ROWS*COLS)  cursor square index = cur_row*COLS+cur_col.
- picked  output  1  high while a source square is held.
- from_idx  output  IW  held source square index.
- to_idx  output  IW  destination square index; valid with move_valid.
- move_valid  output  1  one-cycle pulse: from_idx/to_idx hold a completed move.

## Operation
- Keys are acted on only in a cycle with new_ascii=1. Upper and lower case are both accepted:
  - W (0x57/0x77): row-1
  - S (0x53/0x73): row+1
  - A (0x41/0x61): col-1
  - D (0x44/0x64): col+1
  - ESC (0x1B): cancel
- Any other code is ignored; no output changes.
- Edge behaviour: see Configuration. Without wrap, a move past the edge leaves the cursor unchanged.
- ENTER synchronisation: two-flop synchroniser, a third flop, then rising-edge detect (enter_rise = s2 & ~s3). A held button yields exactly one enter_rise.
- Selection FSM, 2 states:
  - IDLE:
    - enter_rise → latch from_idx = state, picked=1, go to PICKED.
    - ESC ignored.
  - PICKED:
    - enter_rise with state ≠ from_idx → to_idx = state, move_valid=1 for one cycle, picked=0, go to IDLE.
    - enter_rise with state = from_idx → cancel: picked=0, go to IDLE, no pulse.
    - ESC → picked=0, go to IDLE, no pulse.
- Simultaneous enter_rise and new_ascii:
  - The FSM uses the pre-move state value.
  - The cursor move is applied in the same cycle.
  - ESC together with enter_rise: enter_rise wins; ESC is dropped.
- from_idx holds its value after the move or cancel, until the next latch. to_idx holds until the next move.
- Reset values:
  - cur_col=RESET_COL, cur_row=RESET_ROW, state=RESET_ROW*COLS+RESET_COL.
  - picked=0, move_valid=0, from_idx=0, to_idx=0, FSM=IDLE.
  - Synchroniser flops cleared.
- Reset asserted mid-PICKED: the selection is discarded and no move_valid is emitted.

## Timing
- All outputs are registered.
- Key latency: new_ascii high at edge N → cur_col/cur_row/state updated after edge N, visible in cycle N+1.
- state is registered together with cur_col/cur_row. It never lags them.
- ENTER latency: ENTER first sampled high at edge N → enter_rise in cycle N+2. The FSM update (picked, from_idx, move_valid) becomes visible after edge N+3.
- move_valid is high for exactly one cycle. A pulse on ENTER shorter than one CLK period may be missed; no requirement applies to it.
- The block accepts back-to-back new_ascii strobes every cycle.

## Configuration
- CHESS_CURSOR_WRAP_EN defined: edge moves wrap within the same row or column:
  - col COLS-1 + D → 0; col 0 + A → COLS-1
  - row 0 + W → ROWS-1; row ROWS-1 + S → 0
- Macro undefined: edge moves clamp, and the cursor stays on the edge square.

## Test plan
- Reset, default 8×8: cur_col=3, cur_row=3, state=27, picked=0, move_valid=0. Strobe D,D,S → col=5, row=4, state=37, one cycle after each strobe.
- Clamp (macro off): from reset, strobe A four times → col=0. A 5th A leaves col=0, state=24. With WRAP_EN, the 5th A → col=7, state=31.
- Move: ENTER high at edge N → picked=1, from_idx=27 after edge N+3. Strobe W, release and re-press ENTER → one-cycle move_valid with from_idx=27, to_idx=19, then picked=0.
- Cancel paths:
  - ENTER twice on square 27 → no move_valid, picked=0.
  - ENTER, then ESC → picked=0, no pulse.
  - ESC in IDLE → no change.
- Simultaneity: in PICKED (from=27), cursor at 28, enter_rise in the same cycle as strobe D → to_idx=28, cursor moves to 29. Hold ENTER high for 20 cycles → exactly one enter_rise.
- RESET asserted one cycle while picked=1 → picked=0, state=27, no move_valid before or after the reset.
